// File: rtl/lim_sram_bank.sv
// Single-port 64-bit SRAM bank: byte-enabled loads/stores plus bitwise logic-in-memory sweeps.
// Optional per-byte even parity with LIM_SRAM_PARITY_EN defined (default: parity_err_o tied low).
module lim_sram_bank #(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned NumWords     = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [AddrMemWidth-1:0] add_i,
    input  logic                    wen_i,
    input  logic [63:0]             wdata_i,
    input  logic [7:0]              be_i,
    input  logic                    logic_in_memory_i,
    input  logic [2:0]              opcode_mem_i,
    input  logic [31:0]             asize_mem_i,
    output logic [63:0]             rdata_o,
    output logic                    busy_o,
    output logic                    parity_err_o
);
    localparam int unsigned IdxW = $clog2(NumWords);

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      be_q, be_d;
    logic [2:0]      opcode_q, opcode_d;
    logic [63:0]     rdata_q;

    logic [63:0]     mem [NumWords];

    logic [IdxW-1:0] idx;
    logic            accept, lim_accept, lim_start, store_wr, run;
    logic [63:0]     rd_word, run_word, wr_src, wr_base, wr_word;
    logic [7:0]      wr_be;
    logic [IdxW-1:0] wr_addr;
    logic            wr_en;
    logic            unused_addr;

    function automatic logic [63:0] lim_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

    // Address bits outside the word index alias onto the same word.
    assign idx         = add_i[3 +: IdxW];
    assign unused_addr = ^{add_i[2:0], add_i[AddrMemWidth-1:IdxW+3]};

    assign run        = (state_q == RUN);
    assign accept     = req_i && rst_ni && (state_q == IDLE);
    assign lim_accept = accept && wen_i && logic_in_memory_i;
    assign lim_start  = lim_accept && (opcode_mem_i <= 3'd5) && (asize_mem_i != 32'd0);
    assign store_wr   = accept && wen_i && !logic_in_memory_i;

    assign gnt_o   = accept;
    assign busy_o  = run;
    assign rdata_o = rdata_q;

    // Single write port shared by plain stores (IDLE) and the LIM sweep (RUN).
    assign rd_word  = mem[idx];
    assign run_word = mem[ptr_q];
    assign wr_en    = store_wr || run;
    assign wr_addr  = run ? ptr_q : idx;
    assign wr_be    = run ? be_q : be_i;
    assign wr_base  = run ? run_word : rd_word;
    assign wr_src   = run ? lim_op(opcode_q, run_word, wdata_q) : wdata_i;

    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_merge
        assign wr_word[gi*8 +: 8] = wr_be[gi] ? wr_src[gi*8 +: 8] : wr_base[gi*8 +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        opcode_d = opcode_q;
        unique case (state_q)
            IDLE: begin
                if (lim_accept) begin
                    ptr_d    = idx;
                    cnt_d    = asize_mem_i;
                    wdata_d  = wdata_i;
                    be_d     = be_i;
                    opcode_d = opcode_mem_i;
                end
                if (lim_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ptr_d = ptr_q + IdxW'(1);
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            opcode_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            opcode_q <= opcode_d;
            if (accept) begin
                rdata_q <= rd_word;
            end
        end
    end

`ifdef LIM_SRAM_PARITY_EN
    logic [7:0] par_mem [NumWords];
    logic [7:0] wr_par, rd_par;
    logic       parity_err_q;
    logic       force_par_flip;

    // Test hook: overridden from the bench to corrupt byte-0 parity on a write.
    assign force_par_flip = 1'b0;

    for (genvar gi = 0; gi < 8; gi++) begin : g_parity
        assign wr_par[gi] = wr_be[gi] ? ((^wr_word[gi*8 +: 8]) ^ (force_par_flip & (gi == 0)))
                                      : par_mem[wr_addr][gi];
        assign rd_par[gi] = ^rd_word[gi*8 +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            par_mem[wr_addr] <= wr_par;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_err_q <= 1'b0;
        end else if (accept) begin
            parity_err_q <= |(rd_par ^ par_mem[idx]);
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lim_sram_bank.sv
// Directed bench for lim_sram_bank: stimulus pushes expected read data, a monitor pops on each grant.
module tb_lim_sram_bank;
    localparam int unsigned NW = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] add_i = '0;
    logic        wen_i = 1'b0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  be_i = '0;
    logic        logic_in_memory_i = 1'b0;
    logic [2:0]  opcode_mem_i = '0;
    logic [31:0] asize_mem_i = '0;
    logic [63:0] rdata_o;
    logic        busy_o;
    logic        parity_err_o;

    typedef struct packed {
        logic [63:0] data;
        logic        chk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic gnt_seen = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_txn = 0;
    int   waits, busy_seen;

    always #5 clk_i = ~clk_i;

    lim_sram_bank #(.AddrMemWidth(32), .NumWords(NW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
        .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .logic_in_memory_i(logic_in_memory_i),
        .opcode_mem_i(opcode_mem_i), .asize_mem_i(asize_mem_i), .rdata_o(rdata_o),
        .busy_o(busy_o), .parity_err_o(parity_err_o)
    );

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: a grant at one edge means rdata_o carries the response for the next half-cycle.
    always @(posedge clk_i) gnt_seen <= gnt_o;

    always @(negedge clk_i) begin
        if (gnt_seen) begin
            n_txn++;
            if (sb_q.size() == 0) begin
                fail("sb_underflow");
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn %0d: rdata=%h expected=%h checked=%0d", n_txn, rdata_o, mon_e.data, mon_e.chk);
                if (mon_e.chk) check64("rdata", rdata_o, mon_e.data);
            end
        end
    end

    task automatic issue(input logic [31:0] add, input logic wen, input logic [63:0] wd, input logic [7:0] be,
                         input logic lim, input logic [2:0] op, input logic [31:0] asz,
                         input logic [63:0] exp, input logic chk, output int w, output int b);
        w = 0;
        b = 0;
        @(negedge clk_i);
        add_i = add; wen_i = wen; wdata_i = wd; be_i = be;
        logic_in_memory_i = lim; opcode_mem_i = op; asize_mem_i = asz;
        req_i = 1'b1;
        sb_q.push_back('{data: exp, chk: chk});
        #1;
        while (!gnt_o) begin
            if (busy_o) b++;
            w++;
            if (w > 40) begin
                fail("grant_timeout");
                break;
            end
            @(negedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
    endtask

    task automatic st(input logic [31:0] add, input logic [63:0] wd, input logic [7:0] be);
        int w, b;
        issue(add, 1'b1, wd, be, 1'b0, 3'd0, 32'd0, 64'd0, 1'b0, w, b);
    endtask

    task automatic ld(input logic [31:0] add, input logic [63:0] exp);
        int w, b;
        issue(add, 1'b0, 64'd0, 8'h00, 1'b0, 3'd0, 32'd0, exp, 1'b1, w, b);
    endtask

    task automatic lim(input logic [31:0] add, input logic [2:0] op, input logic [63:0] wd,
                       input logic [7:0] be, input logic [31:0] asz, input logic [63:0] pre);
        int w, b;
        issue(add, 1'b1, wd, be, 1'b1, op, asz, pre, 1'b1, w, b);
    endtask

    initial begin
        // Reset state, with a request pending that must not be granted
        req_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_int("reset_gnt", int'(gnt_o), 0);
        check64("reset_rdata", rdata_o, 64'd0);
        check_int("reset_busy", int'(busy_o), 0);
        check_int("reset_parity", int'(parity_err_o), 0);
        req_i = 1'b0;
        rst_ni = 1'b1;

        // Byte-enabled store merge and address aliasing
        st(32'h40, 64'h1122334455667788, 8'hFF);
        issue(32'h40, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 3'd0, 32'd0,
              64'h1122334455667788, 1'b1, waits, busy_seen);
        ld(32'h40, 64'h11223344AAAAAAAA);
        ld(32'hC0, 64'h11223344AAAAAAAA);

        // AND sweep over words 0..3; word 4 must survive
        for (int i = 0; i < 4; i++) st(32'(i * 8), 64'hFFFF0000FFFF0000, 8'hFF);
        st(32'h20, 64'h0123456789ABCDEF, 8'hFF);
        lim(32'h0, 3'b000, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 32'd4, 64'hFFFF0000FFFF0000);
        issue(32'h0, 1'b0, 64'd0, 8'h00, 1'b0, 3'd0, 32'd0, 64'h0F0F00000F0F0000, 1'b1, waits, busy_seen);
        check_int("and_gnt_wait", waits, 4);
        check_int("and_busy_cycles", busy_seen, 4);
        check_int("and_busy_after", int'(busy_o), 0);
        for (int i = 1; i < 4; i++) ld(32'(i * 8), 64'h0F0F00000F0F0000);
        ld(32'h20, 64'h0123456789ABCDEF);

        // XOR byte 0 wrapping from the last word to words 0 and 1
        st(32'((NW - 1) * 8), 64'h00000000000000F0, 8'hFF);
        lim(32'((NW - 1) * 8), 3'b010, 64'hFFFFFFFFFFFFFFFF, 8'h01, 32'd3, 64'h00000000000000F0);
        ld(32'((NW - 1) * 8), 64'h000000000000000F);
        ld(32'h0, 64'h0F0F00000F0F00FF);
        ld(32'h8, 64'h0F0F00000F0F00FF);
        ld(32'h10, 64'h0F0F00000F0F0000);

        // Zero-length and reserved-opcode LIM are single-cycle no-ops
        lim(32'h0, 3'b010, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 32'd0, 64'h0F0F00000F0F00FF);
        check_int("asize0_busy", int'(busy_o), 0);
        issue(32'h0, 1'b0, 64'd0, 8'h00, 1'b0, 3'd0, 32'd0, 64'h0F0F00000F0F00FF, 1'b1, waits, busy_seen);
        check_int("asize0_gnt_wait", waits, 0);
        lim(32'h0, 3'b110, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 32'd5, 64'h0F0F00000F0F00FF);
        check_int("rsvd_busy", int'(busy_o), 0);
        issue(32'h0, 1'b0, 64'd0, 8'h00, 1'b0, 3'd0, 32'd0, 64'h0F0F00000F0F00FF, 1'b1, waits, busy_seen);
        check_int("rsvd_gnt_wait", waits, 0);

        // Load held across a two-word OR sweep sees the post-op value
        lim(32'h10, 3'b001, 64'hF000000000000000, 8'hFF, 32'd2, 64'h0F0F00000F0F0000);
        issue(32'h10, 1'b0, 64'd0, 8'h00, 1'b0, 3'd0, 32'd0, 64'hFF0F00000F0F0000, 1'b1, waits, busy_seen);
        check_int("or_gnt_wait", waits, 2);
        ld(32'h18, 64'hFF0F00000F0F0000);

        // Remaining opcodes, including partial byte enables
        lim(32'h20, 3'b100, 64'h00000000FFFFFFFF, 8'hF0, 32'd1, 64'h0123456789ABCDEF);
        ld(32'h20, 64'hFEDCBA9889ABCDEF);
        lim(32'h40, 3'b101, 64'h11223344AAAAAAAA, 8'hFF, 32'd1, 64'h11223344AAAAAAAA);
        ld(32'h40, 64'hFFFFFFFFFFFFFFFF);
        st(32'h48, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        lim(32'h48, 3'b011, 64'h00000000FFFFFFFF, 8'hFF, 32'd1, 64'hFFFFFFFFFFFFFFFF);
        ld(32'h48, 64'hFFFFFFFF00000000);

        // Reset during the second RUN cycle of an 8-word OR
        st(32'h50, 64'h0000000000001000, 8'hFF);
        st(32'h58, 64'h0000000000002000, 8'hFF);
        lim(32'h50, 3'b001, 64'h000000000000005A, 8'hFF, 32'd8, 64'h0000000000001000);
        @(negedge clk_i);
        check_int("run_busy", int'(busy_o), 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_int("midrun_reset_busy", int'(busy_o), 0);
        check64("midrun_reset_rdata", rdata_o, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        ld(32'h50, 64'h000000000000105A);
        ld(32'h58, 64'h0000000000002000);

`ifdef LIM_SRAM_PARITY_EN
        force dut.force_par_flip = 1'b1;
        st(32'h28, 64'h5555555555555555, 8'hFF);
        release dut.force_par_flip;
        ld(32'h28, 64'h5555555555555555);
        check_int("parity_err_flipped", int'(parity_err_o), 1);
        ld(32'h0, 64'h0F0F00000F0F00FF);
        check_int("parity_err_clean", int'(parity_err_o), 0);
`endif

        repeat (3) @(negedge clk_i);
        check_int("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end
endmodule
